// File: rtl/rf_pkg.sv
// Shared types and constants for the integer register-file writeback slice.
package rf_pkg;

  localparam int unsigned RF_XLEN = 32;

  typedef logic [4:0]         reg_idx_t;
  typedef logic [RF_XLEN-1:0] xlen_t;

  typedef struct packed {
    reg_idx_t rd;
    xlen_t    data;
  } wb_req_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] chk_rs1,
  input  logic [4:0] chk_rs2,
  input  logic [4:0] chk_rd,
  output logic       rs1_busy,
  output logic       rs2_busy,
  output logic       rd_busy
);

  logic [31:0] busy_q;
  logic [31:0] busy_d;

  // Set is applied after clear so a same-cycle re-issue keeps the bit high.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && (clr_idx != REG_ZERO)) begin
      busy_d[clr_idx] = 1'b0;
    end
    if (set_en && (set_idx != REG_ZERO)) begin
      busy_d[set_idx] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = busy_q[chk_rs1];
  assign rs2_busy = busy_q[chk_rs2];
  assign rd_busy  = busy_q[chk_rd];

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file writeback arbiter (memory priority) with one-entry commit stage.
// Define RF_WB_STARVE_EN to compile in the ALU anti-starvation counter.
module rf_wb_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_busy,
  input  logic            a_valid,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            m_valid,
  input  logic [4:0]      m_rd,
  input  logic [XLEN-1:0] m_data,
  output logic            m_ready,
  output logic            rf_write,
  output logic [4:0]      rf_rd_num,
  output logic [XLEN-1:0] rf_data
);

  logic force_arb;
  logic a_hs;
  logic m_hs;

`ifdef RF_WB_STARVE_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;

  assign force_arb = (starve_q == STARVE_LIM);

  always_comb begin
    starve_d = starve_q;
    if (!a_valid || a_ready) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Strict memory priority; STARVE_MAX has no effect in this build.
  assign force_arb = 1'b0 && (STARVE_MAX != 0);
`endif

  assign m_ready = m_valid && !force_arb;
  assign a_ready = a_valid && (!m_valid || force_arb);
  assign a_hs    = a_valid && a_ready;
  assign m_hs    = m_valid && m_ready;

  logic            wr_q,   wr_d;
  logic [4:0]      rd_q,   rd_d;
  logic [XLEN-1:0] data_q, data_d;

  always_comb begin
    wr_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (m_hs) begin
      wr_d   = (m_rd != REG_ZERO);
      rd_d   = m_rd;
      data_d = m_data;
    end else if (a_hs) begin
      wr_d   = (a_rd != REG_ZERO);
      rd_d   = a_rd;
      data_d = a_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  // Gating with rst_n drops a write staged just before reset asserts.
  assign rf_write  = wr_q && rst_n;
  assign rf_rd_num = rd_q;
  assign rf_data   = data_q;

  rf_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_valid),
    .set_idx  (iss_rd),
    .clr_en   (rf_write),
    .clr_idx  (rd_q),
    .chk_rs1  (chk_rs1),
    .chk_rs2  (chk_rs2),
    .chk_rd   (chk_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

endmodule
